// File: rtl/m_madd_pkg.sv
// Shared constants and types for the multiply-add pipe and its block accumulator.
// MADD_LAT must stay equal to the register depth of the madd pipe (y = 3*b + c).
package m_madd_pkg;

    localparam int MADD_LAT  = 3;
    localparam int BLK_DEF   = 4;
    localparam int ACC_W_DEF = 40;

    typedef enum logic {
        S_IDLE,   // no partial block held, cnt == 0
        S_ACC     // partial block held, 0 < cnt < BLK
    } state_e;

endpackage

// File: rtl/m_vld_delay.sv
// LAT-stage valid shift register. It runs alongside the madd pipe, so vld_o
// is high in the cycle where the pipe result for a valid operand is present.
module m_vld_delay #(
    parameter int LAT = 3
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic vld_i,
    output logic vld_o
);

    logic [LAT-1:0] vld_sr_q, vld_sr_d;

    // Next shift value: new valid enters stage 0, every stage moves up by one.
    always_comb begin
        vld_sr_d[0] = vld_i;
        for (int i = 1; i < LAT; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end
    end

    // Shift register with synchronous clear; clearing drops all in-flight valids.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments in clocked blocks so every stage samples pre-edge values.
        if (clr_i) begin
            vld_sr_q <= '0;
        end else begin
            vld_sr_q <= vld_sr_d;
        end
    end

    assign vld_o = vld_sr_q[LAT-1];

endmodule

// File: rtl/m_madd_acc.sv
// Block accumulator behind the multiply-add pipe. Sums every BLK valid pipe
// results and offers each sum on a single-entry valid/ready slot; a sum that
// completes while the slot is still occupied is dropped and r_ovf is set.
// Build option: define M_MADD_ACC_SAT_EN for saturating accumulation with a
// sticky r_sat flag; otherwise the sum wraps and r_sat is tied 0.
module m_madd_acc
    import m_madd_pkg::*;
#(
    parameter int LAT   = MADD_LAT,
    parameter int BLK   = BLK_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic             w_vld_in,
    input  logic [31:0]      w_y,
    input  logic             w_sum_rdy,
    output logic [ACC_W-1:0] r_sum,
    output logic             r_sum_vld,
    output logic             r_ovf,
    output logic             r_sat
);

    localparam int CNT_W = (BLK > 1) ? $clog2(BLK) : 1;

    logic             y_ok;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             sum_vld_q, sum_vld_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] base, y_ext, add_res;
    logic             last, slot_free;

    m_vld_delay #(
        .LAT (LAT)
    ) u_vld_delay (
        .clk_i (w_clk),
        .clr_i (w_rst),
        .vld_i (w_vld_in),
        .vld_o (y_ok)
    );

    // The first result of a block loads the accumulator instead of adding to it.
    assign y_ext     = ACC_W'(w_y);
    assign base      = (state_q == S_IDLE) ? '0 : acc_q;
    assign last      = (cnt_q == CNT_W'(BLK - 1));
    assign slot_free = !sum_vld_q || w_sum_rdy;

`ifdef M_MADD_ACC_SAT_EN
    logic [ACC_W:0] add_full;
    logic           clamp;
    logic           sat_q;

    // One extra bit catches the carry; once clamped to all-ones the sum stays there.
    assign add_full = {1'b0, base} + {1'b0, y_ext};
    assign clamp    = add_full[ACC_W];
    assign add_res  = clamp ? '1 : add_full[ACC_W-1:0];

    // Sticky saturation flag, set by any clamp on an accepted result.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            sat_q <= 1'b0;
        end else if (y_ok && clamp) begin
            sat_q <= 1'b1;
        end
    end

    assign r_sat = sat_q;
`else
    assign add_res = base + y_ext;
    assign r_sat   = 1'b0;
`endif

    // Next-state: block counting FSM, accumulator, output slot and drop flag.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        sum_vld_d = sum_vld_q;
        ovf_d     = ovf_q;

        if (sum_vld_q && w_sum_rdy) begin
            sum_vld_d = 1'b0;
        end

        if (y_ok) begin
            acc_d = add_res;
            if (last) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                if (slot_free) begin
                    sum_d     = add_res;
                    sum_vld_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                state_d = S_ACC;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; synchronous reset discards any partial block.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            sum_vld_q <= sum_vld_d;
            ovf_q     <= ovf_d;
        end
    end

    assign r_sum     = sum_q;
    assign r_sum_vld = sum_vld_q;
    assign r_ovf     = ovf_q;

endmodule
